// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - buffered load/store initiator for the 64 KiB byte-addressed data memory
// Define MEMCTRL_ALIGN_CHECK_EN to fault odd-address word requests instead of issuing them.
module mem_req_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    output logic        m_write_n,
    output logic        m_read_n,
    output logic        m_byte,
    input  logic [15:0] m_rdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [15:0]     f_addr  [DEPTH];
    logic [15:0]     f_wdata [DEPTH];
    logic [DEPTH-1:0] f_write, f_byte;

    logic        push, pop, start;
    logic [15:0] head_addr, head_wdata;
    logic        head_write, head_byte, head_err;

    logic [15:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
    logic        m_write_n_q, m_write_n_d, m_read_n_q, m_read_n_d, m_byte_q, m_byte_d;
    logic        err_q, err_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    assign req_ready = (count_q != CW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == ISSUE);

    // An empty FIFO restarting straight from RESP issues the word being pushed that same edge.
    assign head_addr  = (count_q == '0) ? req_addr  : f_addr[rd_ptr_q];
    assign head_wdata = (count_q == '0) ? req_wdata : f_wdata[rd_ptr_q];
    assign head_write = (count_q == '0) ? req_write : f_write[rd_ptr_q];
    assign head_byte  = (count_q == '0) ? req_byte  : f_byte[rd_ptr_q];

`ifdef MEMCTRL_ALIGN_CHECK_EN
    assign head_err = !head_byte && head_addr[0];
`else
    assign head_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            f_addr[wr_ptr_q]  <= req_addr;
            f_wdata[wr_ptr_q] <= req_wdata;
            f_write[wr_ptr_q] <= req_write;
            f_byte[wr_ptr_q]  <= req_byte;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = ISSUE;
                    start   = 1'b1;
                end
            end
            ISSUE: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    if (count_d != '0) begin
                        state_d = ISSUE;
                        start   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_addr_d    = 16'h0000;
        m_wdata_d   = 16'h0000;
        m_write_n_d = 1'b1;
        m_read_n_d  = 1'b1;
        m_byte_d    = 1'b0;
        err_d       = err_q;
        if (start) begin
            err_d = head_err;
            if (!head_err) begin
                m_addr_d = head_addr;
                m_byte_d = head_byte;
                if (head_write) begin
                    m_write_n_d = 1'b0;
                    m_wdata_d   = head_wdata;
                end else begin
                    m_read_n_d = 1'b0;
                end
            end
        end
    end

    // Read data is captured only for a load that actually strobed; stores and faults return zero.
    always_comb begin
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        if (state_q == ISSUE) begin
            rsp_data_d = m_read_n_q ? 16'h0000 : m_rdata;
            rsp_err_d  = err_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            m_addr_q    <= 16'h0000;
            m_wdata_q   <= 16'h0000;
            m_write_n_q <= 1'b1;
            m_read_n_q  <= 1'b1;
            m_byte_q    <= 1'b0;
            err_q       <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_write_n_q <= m_write_n_d;
            m_read_n_q  <= m_read_n_d;
            m_byte_q    <= m_byte_d;
            err_q       <= err_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_write_n = m_write_n_q;
    assign m_read_n  = m_read_n_q;
    assign m_byte    = m_byte_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - self-checking bench for mem_req_ctrl with a behavioural memory and scoreboard
module tb_mem_req_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_byte;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [15:0] rsp_data;
    logic [15:0] m_addr, m_wdata, m_rdata, a_next;
    logic        m_write_n, m_read_n, m_byte;

    mem_req_ctrl #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_write_n(m_write_n), .m_read_n(m_read_n),
        .m_byte(m_byte), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        write;
        logic        bsel;
    } iss_t;

    logic [7:0]  mem     [65536];
    logic [7:0]  ref_mem [65536];
    logic [15:0] exp_data_q [$];
    logic        exp_err_q  [$];
    iss_t        iss_q      [$];
    logic [15:0] log_data   [$];
    logic        log_err    [$];

    int n_checks = 0, n_fail = 0, cycle = 0, last_hs = -10;
    int wr_low_cnt = 0, rd_low_cnt = 0, rsp_count = 0;

    assign a_next  = m_addr + 16'd1;
    assign m_rdata = m_byte ? {8'h00, mem[m_addr]} : {mem[m_addr], mem[a_next]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: requests take effect in acceptance order, one response each.
    task automatic model_accept(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
        logic        err;
        logic [15:0] a1;
        iss_t        e;
        a1 = a + 16'd1;
`ifdef MEMCTRL_ALIGN_CHECK_EN
        err = !b && a[0];
`else
        err = 1'b0;
`endif
        if (err) begin
            exp_data_q.push_back(16'h0000);
            exp_err_q.push_back(1'b1);
        end else begin
            e.addr = a; e.wdata = d; e.write = w; e.bsel = b;
            iss_q.push_back(e);
            if (w) begin
                if (b) ref_mem[a] = d[7:0];
                else begin
                    ref_mem[a]  = d[15:8];
                    ref_mem[a1] = d[7:0];
                end
                exp_data_q.push_back(16'h0000);
            end else begin
                exp_data_q.push_back(b ? {8'h00, ref_mem[a]} : {ref_mem[a], ref_mem[a1]});
            end
            exp_err_q.push_back(1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        forever begin
            @(posedge clk);
            if (!m_write_n) begin
                if (m_byte) mem[m_addr] = m_wdata[7:0];
                else begin
                    mem[m_addr] = m_wdata[15:8];
                    mem[a_next] = m_wdata[7:0];
                end
            end
        end
    end

    initial begin
        iss_t e;
        logic [15:0] ed;
        logic        ee;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
        forever begin
            @(negedge clk);
            cycle++;
            if (reset) begin
                if (rsp_valid && rsp_ready) begin
                    chk("rsp_pending", exp_data_q.size() != 0, 1);
                    if (exp_data_q.size() != 0) begin
                        ed = exp_data_q.pop_front();
                        ee = exp_err_q.pop_front();
                        chk("rsp_data", rsp_data, ed);
                        chk("rsp_err", rsp_err, ee);
                    end
                    log_data.push_back(rsp_data);
                    log_err.push_back(rsp_err);
                    rsp_count++;
                    chk("rsp_spacing", (cycle - last_hs) >= 2, 1);
                    last_hs = cycle;
                end
                if (!m_write_n || !m_read_n) begin
                    chk("strobe_exclusive", m_write_n | m_read_n, 1);
                    chk("issue_pending", iss_q.size() != 0, 1);
                    if (iss_q.size() != 0) begin
                        e = iss_q.pop_front();
                        chk("m_addr", m_addr, e.addr);
                        chk("m_byte", m_byte, e.bsel);
                        chk("m_write_n", m_write_n, !e.write);
                        if (e.write) chk("m_wdata", m_wdata, e.wdata);
                    end
                    if (!m_write_n) wr_low_cnt++;
                    if (!m_read_n) rd_low_cnt++;
                end else begin
                    chk("idle_port", (m_addr == 16'h0 && m_wdata == 16'h0 && !m_byte), 1);
                end
                if (req_valid && req_ready) model_accept(req_write, req_byte, req_addr, req_wdata);
            end
        end
    end

    task automatic send(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
        logic ok;
        int   n;
        req_write = w; req_byte = b; req_addr = a; req_wdata = d; req_valid = 1'b1;
        ok = 1'b0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            n++;
        end
        #1 req_valid = 1'b0;
        chk("req_accept", ok, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_data_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", exp_data_q.size(), 0);
    endtask

    task automatic chk_log(input int idx, input logic [15:0] d, input logic e);
        chk("log_present", log_data.size() > idx, 1);
        if (log_data.size() > idx) begin
            chk("log_data", log_data[idx], d);
            chk("log_err", log_err[idx], e);
        end
    endtask

    initial begin
        int rdc, rc, n0;
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_addr = 16'h0; req_wdata = 16'h0; rsp_ready = 1'b0;
        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 16'h0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_strobes", {m_write_n, m_read_n, m_byte}, 3'b110);
        chk("rst_m_addr", m_addr, 16'h0);
        @(posedge clk); #1 reset = 1'b1;

        rsp_ready = 1'b1;
        send(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        @(negedge clk); chk("lat_t0_valid", rsp_valid, 0);
        @(negedge clk);
        chk("lat_issue_wn", m_write_n, 0);
        chk("lat_issue_addr", m_addr, 16'h0010);
        chk("lat_t1_valid", rsp_valid, 0);
        @(negedge clk); chk("lat_t2_valid", rsp_valid, 1);
        @(posedge clk); #1;
        send(1'b0, 1'b0, 16'h0010, 16'h0000);
        wait_idle();
        chk("store_strobe_cycles", wr_low_cnt, 1);
        chk_log(0, 16'h0000, 1'b0);
        chk_log(1, 16'hBEEF, 1'b0);

        send(1'b0, 1'b1, 16'h0011, 16'h0000);
        send(1'b1, 1'b1, 16'h0010, 16'h1234);
        send(1'b0, 1'b0, 16'h0010, 16'h0000);
        wait_idle();
        chk_log(2, 16'h00EF, 1'b0);
        chk_log(3, 16'h0000, 1'b0);
        chk_log(4, 16'h34EF, 1'b0);

        rsp_ready = 1'b0;
        n0 = rsp_count;
        send(1'b0, 1'b0, 16'h0010, 16'h0000);
        send(1'b0, 1'b1, 16'h0011, 16'h0000);
        send(1'b0, 1'b1, 16'h0010, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_req_ready", req_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_no_rsp", rsp_count, n0);
        fork
            send(1'b0, 1'b0, 16'h0010, 16'h0000);
            begin
                repeat (2) @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        wait_idle();
        chk_log(5, 16'h34EF, 1'b0);
        chk_log(6, 16'h00EF, 1'b0);
        chk_log(7, 16'h0034, 1'b0);
        chk_log(8, 16'h34EF, 1'b0);

        rdc = rd_low_cnt;
        send(1'b0, 1'b0, 16'h0005, 16'h0000);
        wait_idle();
`ifdef MEMCTRL_ALIGN_CHECK_EN
        chk_log(9, 16'h0000, 1'b1);
        chk("odd_word_no_strobe", rd_low_cnt, rdc);
`else
        chk_log(9, 16'h0000, 1'b0);
        chk("odd_word_strobe", rd_low_cnt, rdc + 1);
`endif
        send(1'b0, 1'b1, 16'h0005, 16'h0000);
        send(1'b1, 1'b0, 16'hFFFF, 16'hA55A);
        send(1'b0, 1'b1, 16'hFFFF, 16'h0000);
        wait_idle();
        chk_log(10, 16'h0000, 1'b0);
`ifdef MEMCTRL_ALIGN_CHECK_EN
        chk_log(11, 16'h0000, 1'b1);
        chk_log(12, 16'h0000, 1'b0);
`else
        chk_log(11, 16'h0000, 1'b0);
        chk_log(12, 16'h00A5, 1'b0);
`endif

        rsp_ready = 1'b0;
        send(1'b0, 1'b0, 16'h0010, 16'h0000);
        send(1'b0, 1'b0, 16'h0012, 16'h0000);
        send(1'b0, 1'b1, 16'h0013, 16'h0000);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        exp_data_q.delete();
        exp_err_q.delete();
        iss_q.delete();
        #1;
        chk("mrst_rsp_valid", rsp_valid, 0);
        chk("mrst_req_ready", req_ready, 1);
        chk("mrst_rsp_data", rsp_data, 16'h0);
        chk("mrst_rsp_err", rsp_err, 0);
        chk("mrst_strobes", {m_write_n, m_read_n, m_byte}, 3'b110);
        chk("mrst_m_addr", m_addr, 16'h0);
        rc = rsp_count;
        @(posedge clk); #1 reset = 1'b1;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_no_rsp", rsp_count, rc);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_req_ready", req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time=%0t required_before=500000", $time);
        $fatal(1);
    end
endmodule
